// File: rtl/ibex_ahb_ram.sv
// AHB-style single-port RAM slave behind ibex_interface.
// Configurable wait states, two-cycle error response.
module ibex_ahb_ram #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  TRF,
  input  logic [2:0]  SIZE,
  input  logic [31:0] DIR,
  input  logic [2:0]  BRSTsz,
  input  logic        WRITE,
  input  logic [31:0] DATW,
  output logic [31:0] READDAT,
  output logic        RDY,
  output logic        ERR
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [MEM_WORDS];

  logic [31:0] offset;
  logic        in_rng;
  logic        misal;
  logic        acc_err;
  logic        rdy;
  logic        accept;
  logic [3:0]  be;
  logic        unused_bits;

  assign offset  = DIR - BASE_ADDR;
  assign in_rng  = (DIR >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign misal   = ((SIZE == 3'b001) && DIR[0]) ||
                   ((SIZE == 3'b010) && (DIR[1:0] != 2'b00));
  assign acc_err = !in_rng || (SIZE > 3'b010) || misal;

  assign rdy     = (state_q == S_IDLE) || (state_q == S_DONE) ||
                   (state_q == S_ERR2);
  assign accept  = rdy && TRF[1];

  assign RDY     = rdy;
  assign ERR     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign READDAT = rdata_q;

  assign unused_bits = ^{BRSTsz, TRF[0], offset[31:AW+2], offset[1:0]};

  // Byte-lane enables of the latched transfer
  always_comb begin
    be = 4'b0000;
    unique case (size_q)
      3'b000:  be[lane_q] = 1'b1;
      3'b001:  be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Next state, wait counter, address-phase latch and read capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      S_DONE: begin
        state_d = S_IDLE;
        // a prior write already committed on its own DONE edge,
        // so a back-to-back read sees the merged word here
        if (!wr_q) rdata_d = mem_q[idx_q];
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      idx_d  = offset[AW+1:2];
      lane_d = DIR[1:0];
      size_d = SIZE;
      wr_d   = WRITE;
      if (acc_err) begin
        state_d = S_ERR1;
        cnt_d   = 4'd0;
      end else if (WAIT_STATES > 0) begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_STATES);
      end else begin
        state_d = S_DONE;
        cnt_d   = 4'd0;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      size_q  <= 3'b000;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array: contents survive reset, written on write DONE
  always_ff @(posedge clk_i) begin
    if ((state_q == S_DONE) && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx_q][8*b +: 8] <= DATW[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ibex_ahb_ram.sv
// Randomized bench for ibex_ahb_ram against a word-array model.
// Three instances cover 0, 1 and 3 wait states.
module tb_ibex_ahb_ram;

  localparam int MW = 64;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [1:0]  trf;
  logic [2:0]  size;
  logic [31:0] dir;
  logic [2:0]  brst;
  logic        write;
  logic [31:0] datw;
  int          sel;

  logic [31:0] rd_w  [3];
  logic        rdy_w [3];
  logic        err_w [3];

  int ws [3] = '{0, 1, 3};
  logic [31:0] mdl [3][MW];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ibex_ahb_ram #(.MEM_WORDS(MW), .WAIT_STATES(0)) u_w0 (
    .clk_i(clk), .rst_ni(rst_n[0]),
    .TRF(sel == 0 ? trf : 2'b00), .SIZE(size), .DIR(dir),
    .BRSTsz(brst), .WRITE(write), .DATW(datw),
    .READDAT(rd_w[0]), .RDY(rdy_w[0]), .ERR(err_w[0])
  );

  ibex_ahb_ram #(.MEM_WORDS(MW), .WAIT_STATES(1)) u_w1 (
    .clk_i(clk), .rst_ni(rst_n[1]),
    .TRF(sel == 1 ? trf : 2'b00), .SIZE(size), .DIR(dir),
    .BRSTsz(brst), .WRITE(write), .DATW(datw),
    .READDAT(rd_w[1]), .RDY(rdy_w[1]), .ERR(err_w[1])
  );

  ibex_ahb_ram #(.MEM_WORDS(MW), .WAIT_STATES(3)) u_w3 (
    .clk_i(clk), .rst_ni(rst_n[2]),
    .TRF(sel == 2 ? trf : 2'b00), .SIZE(size), .DIR(dir),
    .BRSTsz(brst), .WRITE(write), .DATW(datw),
    .READDAT(rd_w[2]), .RDY(rdy_w[2]), .ERR(err_w[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
    if (a >= 32'(MW * 4)) return 1'b1;
    if (sz > 3'd2) return 1'b1;
    if (sz == 3'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 3'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void mdl_write(input int d, input logic [31:0] a,
                                    input logic [2:0] sz,
                                    input logic [31:0] wd);
    int w  = int'(a / 4);
    int lo = int'(a % 4);
    int nb = 1 << sz;
    for (int b = lo; b < lo + nb; b++)
      mdl[d][w][8*b +: 8] = wd[8*b +: 8];
  endfunction

  // Non-pipelined transfer with full RDY/ERR timeline check
  task automatic do_xfer(input int d, input bit wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd,
                         input string tag);
    bit e = is_err(a, sz);
    logic [31:0] exp = 32'h0;
    if (!e) exp = mdl[d][a / 4];
    if (wr && !e) mdl_write(d, a, sz, wd);
    @(negedge clk);
    trf = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
    dir = a; size = sz; write = wr;
    @(negedge clk);
    trf = 2'($urandom_range(0, 1));
    datw = wd; dir = $urandom;
    if (e) begin
      chk({tag, ".e1rdy"}, {31'b0, rdy_w[d]}, 32'd0);
      chk({tag, ".e1err"}, {31'b0, err_w[d]}, 32'd1);
      @(negedge clk);
      chk({tag, ".e2rdy"}, {31'b0, rdy_w[d]}, 32'd1);
      chk({tag, ".e2err"}, {31'b0, err_w[d]}, 32'd1);
    end else begin
      for (int k = 1; k <= ws[d] + 1; k++) begin
        if (k > 1) @(negedge clk);
        chk({tag, ".rdy"}, {31'b0, rdy_w[d]}, 32'(k == ws[d] + 1));
        chk({tag, ".err"}, {31'b0, err_w[d]}, 32'd0);
      end
    end
    @(negedge clk);
    chk({tag, ".idle_rdy"}, {31'b0, rdy_w[d]}, 32'd1);
    chk({tag, ".idle_err"}, {31'b0, err_w[d]}, 32'd0);
    if (!wr && !e) chk({tag, ".rdata"}, rd_w[d], exp);
  endtask

  task automatic rand_xfer(input int d);
    int r = $urandom_range(0, 9);
    logic [2:0]  sz;
    logic [31:0] a;
    sz = (r == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    a  = 32'($urandom_range(0, MW - 1)) * 4;
    if (r == 1) a = a + 32'($urandom_range(1, 3));
    else if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
    else if (sz == 3'd1) a = a + 32'($urandom_range(0, 1)) * 2;
    if (r == 2) a = 32'(MW * 4) + ($urandom & 32'hFFF);
    if (r == 3) a = $urandom | 32'h8000_0000;
    do_xfer(d, ($urandom_range(0, 1) == 1), a, sz, $urandom, "rnd");
  endtask

  task automatic init_mem(input int d);
    for (int w = 0; w < MW; w++)
      do_xfer(d, 1'b1, 32'(w) * 4, 3'd2, $urandom, "init");
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] exp;
  } txn_t;

  // Back-to-back stream on the zero-wait-state instance
  task automatic pipe_stream(input int n);
    txn_t q [$];
    txn_t t;
    t = '{1'b1, 32'h8, 3'd2, 32'hCAFEF00D, 32'h0};
    q.push_back(t);
    t = '{1'b0, 32'h8, 3'd2, 32'h0, 32'h0};
    q.push_back(t);
    for (int i = 0; i < n; i++) begin
      t.wr = ($urandom_range(0, 1) == 1);
      t.sz = 3'($urandom_range(0, 2));
      t.a  = 32'($urandom_range(0, 7)) * 4;
      if (t.sz == 3'd0) t.a = t.a + 32'($urandom_range(0, 3));
      if (t.sz == 3'd1) t.a = t.a + 32'($urandom_range(0, 1)) * 2;
      t.wd = $urandom;
      q.push_back(t);
    end
    foreach (q[i]) begin
      q[i].exp = mdl[0][q[i].a / 4];
      if (q[i].wr) mdl_write(0, q[i].a, q[i].sz, q[i].wd);
    end
    for (int i = 0; i <= q.size() + 1; i++) begin
      @(negedge clk);
      if (i < q.size()) begin
        trf = 2'b10; dir = q[i].a; size = q[i].sz; write = q[i].wr;
      end else begin
        trf = 2'b00; dir = $urandom;
      end
      if (i >= 1 && i - 1 < q.size()) datw = q[i-1].wd;
      chk("pipe.rdy", {31'b0, rdy_w[0]}, 32'd1);
      chk("pipe.err", {31'b0, err_w[0]}, 32'd0);
      if (i >= 2 && !q[i-2].wr) chk("pipe.rdata", rd_w[0], q[i-2].exp);
    end
  endtask

  initial begin
    sel = 0; rst_n = 3'b000;
    trf = 2'b10; size = 3'b010; dir = $urandom; brst = 3'b011;
    write = 1'b1; datw = $urandom;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst.rdy", {31'b0, rdy_w[d]}, 32'd1);
      chk("rst.err", {31'b0, err_w[d]}, 32'd0);
      chk("rst.rdata", rd_w[d], 32'h0);
    end
    @(negedge clk);
    trf = 2'b00;
    rst_n = 3'b111;

    // One wait state: directed then random
    sel = 1;
    init_mem(1);
    do_xfer(1, 1'b1, 32'h4, 3'd2, 32'hDEADBEEF, "w1.wr4");
    do_xfer(1, 1'b0, 32'h4, 3'd2, 32'h0, "w1.rd4");
    chk("w1.deadbeef", rd_w[1], 32'hDEADBEEF);
    do_xfer(1, 1'b1, 32'h0, 3'd2, 32'h11223344, "w1.wr0");
    do_xfer(1, 1'b1, 32'h2, 3'd0, 32'h00AA0000, "w1.wrb");
    do_xfer(1, 1'b0, 32'h0, 3'd2, 32'h0, "w1.rd0");
    chk("w1.bytelane", rd_w[1], 32'h11AA3344);
    do_xfer(1, 1'b0, 32'(MW * 4), 3'd2, 32'h0, "w1.oor");
    do_xfer(1, 1'b1, 32'h6, 3'd2, 32'h12345678, "w1.mis");
    do_xfer(1, 1'b0, 32'h4, 3'd2, 32'h0, "w1.rd4b");
    chk("w1.unchanged", rd_w[1], 32'hDEADBEEF);
    repeat (60) rand_xfer(1);

    // Zero wait states: pipelined stream with forwarding
    sel = 0;
    init_mem(0);
    pipe_stream(40);
    repeat (40) rand_xfer(0);

    // Three wait states: random, then reset in the second WAIT cycle
    sel = 2;
    init_mem(2);
    repeat (40) rand_xfer(2);
    @(negedge clk);
    trf = 2'b10; dir = 32'hC; size = 3'd2; write = 1'b1;
    @(negedge clk);
    trf = 2'b00; datw = ~mdl[2][3];
    chk("w3.wait1", {31'b0, rdy_w[2]}, 32'd0);
    @(posedge clk);
    #2;
    rst_n[2] = 1'b0;
    #1;
    chk("w3.rst_rdy", {31'b0, rdy_w[2]}, 32'd1);
    chk("w3.rst_err", {31'b0, err_w[2]}, 32'd0);
    chk("w3.rst_rdata", rd_w[2], 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n[2] = 1'b1;
    do_xfer(2, 1'b0, 32'hC, 3'd2, 32'h0, "w3.rdC");
    repeat (20) rand_xfer(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
